fir_sample_packer: RTL
======================

Name: fir_sample_packer

Overview:
Source-side front end for the decimating FIR. Takes one sample per channel per cycle from the ADC/averaging stage, which cannot be stalled. Packs PSAMPLES consecutive samples per channel into one wide beat and presents it on the FIR's valid/ready input stream. Provides two frames of output buffering and detects and counts dropped frames when the FIR back-pressures too long.

Parameters:
CHANNELS, 2, number of interleaved channels
DW, 16, sample width in bits (signed, passed through untouched)
PSAMPLES, 8, samples per channel per output beat
CNTW, 16, width of the dropped-frame counter

Ports:
clk  input  1  system clock, all logic rising-edge
nrst  input  1  asynchronous active-low reset
in_valid  input  1  one new sample per channel this cycle; never stalled
in_data  input  CHANNELS*DW  channel c sample at bits [c*DW +: DW]
m_tvalid  output  1  packed beat available
m_tready  input  1  FIR accepts beat (s_tready of FIR)
m_tdata  output  CHANNELS*DW*PSAMPLES  packed beat (to FIR s_tdata)
overflow  output  1  sticky: at least one frame dropped
ovf_clr  input  1  synchronous clear of overflow and drop_count
drop_count  output  CNTW  saturating count of dropped frames

Behaviour:
- Reset (nrst low, async): m_tvalid=0, m_tdata=0, overflow=0, drop_count=0, fill index=0, pending slot empty. Any partial frame or buffered beat is discarded.
- Packing: channel c, sample k (k = arrival order within frame, 0 first) lands at m_tdata[(c*PSAMPLES + k)*DW +: DW]. Channel 0 occupies the low PSAMPLES*DW bits; channel 1 the next block.
- Assembly: each in_valid cycle writes in_data into slot k of the assembly register and increments k. Cycles with in_valid=0 change nothing. Gaps are allowed.
- Frame completion: the cycle in_valid arrives with k=PSAMPLES-1. k wraps to 0 in that same cycle, so the next sample starts a new frame with no bubble.
- Storage: an output register (drives m_tdata/m_tvalid) plus one pending slot.
- Handshake: a beat transfers when m_tvalid && m_tready. m_tdata is held stable while m_tvalid=1 and m_tready=0. m_tvalid does not depend combinationally on m_tready.
- Completed frame F, evaluated on the completion edge, in priority order:
  1. Output register empty, or transferring this cycle, and pending empty: F loads the output register. m_tvalid=1 on the next cycle, so latency is 1 clock from the final sample.
  2. Output transferring this cycle and pending full: pending moves to output; F moves to pending. No drop.
  3. Output full, not transferring, pending empty: F goes to pending.
  4. Output full, not transferring, pending full: F is dropped. overflow<=1; drop_count increments, saturating at all-ones.
- No frame completion but output transferring: pending (if full) moves to output, so beats stream back-to-back. Otherwise m_tvalid<=0.
- Beats always leave in arrival order. A dropped frame is always the newest one.
- ovf_clr: overflow<=0 and drop_count<=0 next cycle. If a drop happens in the same cycle, the drop wins: overflow=1, drop_count=1.
- nrst asserted mid-frame or mid-handshake aborts everything. After release, the first in_valid is sample 0 of a new frame.

Test Plan:
- Basic pack: m_tready=1; 8 consecutive in_valid with ch0=k, ch1=0x100+k (k=0..7) -> m_tvalid=1 exactly one cycle after the 8th; m_tdata[16k+:16]=k and [128+16k+:16]=0x100+k; m_tvalid=0 on the following cycle.
- Gapped input: same 8 samples with in_valid low every other cycle -> identical m_tdata; m_tvalid only after the 8th valid sample.
- Backpressure/drop: m_tready=0; 24 continuous samples (values 0..23) -> overflow=1, drop_count=1. Then set m_tready=1 -> beats with samples 0..7 then 8..15 in consecutive cycles; samples 16..23 are never output.
- Simultaneous completion + drain: output and pending full; m_tready=1 asserted in the same cycle a third frame completes -> no drop; the three beats appear in order; overflow stays 0.
- Reset mid-frame: 5 samples, pulse nrst low for 1 cycle, then 8 samples 0x40..0x47 -> one beat containing exactly 0x40..0x47 in lanes 0..7; m_tvalid=0 and m_tdata=0 during reset.
- Clear/saturation: CNTW=2, force 5 drops -> drop_count=3. Pulse ovf_clr -> overflow=0, drop_count=0. Pulse ovf_clr in the same cycle as a drop -> overflow=1, drop_count=1.

Source files
------------

// File: rtl/fir_sample_packer.sv
// Packs PSAMPLES samples per channel into one wide beat for the decimating FIR.
// The input side cannot stall. The output side holds one output register plus one pending slot.
module fir_sample_packer #(
    parameter int CHANNELS = 2,
    parameter int DW       = 16,
    parameter int PSAMPLES = 8,
    parameter int CNTW     = 16
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            in_valid,
    input  logic [CHANNELS*DW-1:0]          in_data,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic [CHANNELS*DW*PSAMPLES-1:0] m_tdata,
    output logic                            overflow,
    input  logic                            ovf_clr,
    output logic [CNTW-1:0]                 drop_count
);
    localparam int BW = CHANNELS * DW * PSAMPLES;
    localparam int KW = (PSAMPLES > 1) ? $clog2(PSAMPLES) : 1;

    logic [BW-1:0]   asm_q, asm_d;
    logic [KW-1:0]   idx_q, idx_d;
    logic [BW-1:0]   out_q, out_d;
    logic            out_vld_q, out_vld_d;
    logic [BW-1:0]   pend_q, pend_d;
    logic            pend_vld_q, pend_vld_d;
    logic            ovf_q, ovf_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [BW-1:0]   frame;
    logic            frame_done;
    logic            xfer;
    logic            drop;

    // Assembly register with this cycle's samples merged in.
    // This is the completed frame when frame_done is high.
    always_comb begin
        frame = asm_q;
        for (int c = 0; c < CHANNELS; c++) begin
            frame[(c*PSAMPLES + int'(idx_q))*DW +: DW] = in_data[c*DW +: DW];
        end
    end

    assign frame_done = in_valid && (idx_q == KW'(PSAMPLES - 1));
    assign xfer       = out_vld_q && m_tready;

    always_comb begin
        asm_d      = asm_q;
        idx_d      = idx_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        drop       = 1'b0;

        if (in_valid) begin
            asm_d = frame;
            idx_d = frame_done ? '0 : idx_q + KW'(1);
        end

        if (frame_done) begin
            if ((!out_vld_q || xfer) && !pend_vld_q) begin
                out_d     = frame;
                out_vld_d = 1'b1;
            end else if (xfer) begin
                out_d  = pend_q;
                pend_d = frame;
            end else if (!pend_vld_q) begin
                pend_d     = frame;
                pend_vld_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (xfer) begin
            if (pend_vld_q) begin
                out_d      = pend_q;
                pend_vld_d = 1'b0;
            end else begin
                out_vld_d = 1'b0;
            end
        end

        // A drop in the same cycle as a clear restarts the count at one.
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr)
                cnt_d = CNTW'(1);
            else if (cnt_q != '1)
                cnt_d = cnt_q + CNTW'(1);
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            asm_q      <= '0;
            idx_q      <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            asm_q      <= asm_d;
            idx_q      <= idx_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign m_tvalid   = out_vld_q;
    assign m_tdata    = out_q;
    assign overflow   = ovf_q;
    assign drop_count = cnt_q;
endmodule
